// File: rtl/run_control_pkg.sv
// Shared types for the board run controller: mode encoding and cycle-counter width.
package run_control_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_e;

  localparam int unsigned CYCLE_CNT_W = 32;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter, and a
// registered one-cycle press pulse on each accepted 0->1 level change.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    // The increment that would reach DEBOUNCE_CYCLES accepts the new level instead.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/run_control.sv
// Run/halt/single-step controller driving the CPU clock enable and divider select.
// Optional cycle counter enabled by defining RUN_CONTROL_CYCLE_CNT_EN.
//
// state | meaning
// HALT  | CPU stopped, waiting for run or step press
// RUN   | CPU free-running until halt_req or run press
// STEP  | one CPU cycle, ends on the next observed cpu_tick
module run_control
  import run_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_freq,
  input  logic                   btn_run,
  input  logic                   btn_step,
  input  logic                   halt_req,
  input  logic                   cpu_tick,
  output logic                   frequency,
  output logic                   cpu_en,
  output logic [1:0]             state,
  output logic [CYCLE_CNT_W-1:0] cycle_count
);

  logic       press_freq, press_run, press_step;
  run_state_e state_q, state_d;
  logic       cpu_en_q, cpu_en_d;
  logic       freq_q, freq_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freq (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_freq), .press(press_freq));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_run), .press(press_run));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_step), .press(press_step));

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q ^ press_freq;
    cpu_en_d = (state_q == RUN) || (state_q == STEP);
    unique case (state_q)
      HALT: begin
        if (halt_req)        state_d = HALT;
        else if (press_run)  state_d = RUN;
        else if (press_step) state_d = STEP;
      end
      RUN: begin
        if (halt_req || press_run) state_d = HALT;
      end
      // halt_req deliberately does not abort a step in flight.
      STEP: begin
        if (cpu_tick) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HALT;
      cpu_en_q <= 1'b0;
      freq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      freq_q   <= freq_d;
    end
  end

`ifdef RUN_CONTROL_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (cpu_tick && cpu_en_q) cycle_cnt_d = cycle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cycle_cnt_q <= '0;
    else        cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_count = cycle_cnt_q;
`else
  assign cycle_count = '0;
`endif

  assign frequency = freq_q;
  assign cpu_en    = cpu_en_q;
  assign state     = state_q;

endmodule
